// File: rtl/fetch_issue_unit.sv
// ---------------------------------------------------------------------------
// fetch_issue_unit
//   Instruction fetch/issue sequencer for the 16-bit CISC-V core. Holds the
//   PC, fetches one 16-bit word at a time from instruction memory and
//   presents it to decode. Redirects the PC on jmp and on taken bne, the
//   latter after the datapath resolves the branch.
//
// Handshakes (strict valid/ready semantics):
//   imem_req/imem_ready : a fetch transfers in the cycle where both are high;
//                         imem_rdata is only looked at in that cycle.
//                         imem_addr is held stable while imem_req waits.
//   instr_valid/instr_ack: an instruction transfers to decode in the cycle
//                         where both are high; instr/opcode/pc_o hold until
//                         then.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   imem_req/addr   fetch request and word address (= pc)
//   imem_ready      memory accepts request, imem_rdata valid
//   imem_rdata      fetched instruction word
//   instr_valid     issued instruction valid
//   instr/opcode    issued word and its opcode field [15:12]
//   pc_o            address of the issued instruction
//   instr_ack       decode consumes the issued instruction
//   br_resolve      datapath has evaluated the pending bne
//   br_taken        bne outcome, qualified by br_resolve
//   br_pending      waiting for branch resolution
//   dbg_state       current FSM state (0=REQ, 1=ISSUE, 2=WAIT_BR)
//
// All outputs decode directly from registers; no input reaches an output
// combinationally. Only one instruction is ever in flight.
// ---------------------------------------------------------------------------
module fetch_issue_unit #(
  parameter int          ADDR_W   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  OPC_JMP  = 4'b1111,
  parameter logic [3:0]  OPC_BNE  = 4'b1110
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [15:0]       imem_rdata,
  output logic              instr_valid,
  output logic [15:0]       instr,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              instr_ack,
  input  logic              br_resolve,
  input  logic              br_taken,
  output logic              br_pending,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_BR = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_pc_o;
  logic [15:0]         r_instr;

  logic [ADDR_W-1:0]   w_pc_next;
  logic [ADDR_W-1:0]   w_jmp_target;
  logic [ADDR_W-1:0]   w_br_off;

  // Fall-through address of the issued instruction; wraps modulo 2^ADDR_W.
  assign w_pc_next    = r_pc_o + ADDR_W'(1);
  // jmp keeps the 4-bit page of the fall-through address, replaces the rest.
  assign w_jmp_target = {w_pc_next[ADDR_W-1:12], r_instr[11:0]};
  // bne offset: 4-bit two's complement, sign-extended to the PC width.
  assign w_br_off     = {{(ADDR_W-4){r_instr[3]}}, r_instr[3:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_REQ;
      r_pc    <= ADDR_W'(RESET_PC);
      r_pc_o  <= '0;
      r_instr <= '0;
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_pc_o  <= r_pc;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (instr_ack) begin
            if (r_instr[15:12] == OPC_JMP) begin
              r_pc    <= w_jmp_target;
              r_state <= S_REQ;
            end else if (r_instr[15:12] == OPC_BNE) begin
              r_state <= S_WAIT_BR;
            end else begin
              r_pc    <= w_pc_next;
              r_state <= S_REQ;
            end
          end
        end
        S_WAIT_BR: begin
          if (br_resolve) begin
            r_pc    <= br_taken ? (w_pc_next + w_br_off) : w_pc_next;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == S_ISSUE);
  assign instr       = r_instr;
  assign opcode      = r_instr[15:12];
  assign pc_o        = r_pc_o;
  assign br_pending  = (r_state == S_WAIT_BR);
  assign dbg_state   = r_state;

endmodule
